// File: rtl/gnrl_pipe_fifo_pkg.sv
// Shared constants and helpers for the gnrl_pipe_fifo elastic buffer.
package gnrl_pipe_fifo_pkg;

   localparam int DP_MIN = 1;
   localparam int DP_MAX = 64;

   // Bits needed to index/count up to v-1; never returns less than 1.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/gnrl_dfflra.sv
// Load-enable flop bank with asynchronous active-high reset to zero.
module gnrl_dfflra #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       q_o <= '0;
      else if (en_i) q_o <= d_i;
   end

endmodule

// File: rtl/gnrl_pipe_fifo.sv
// DP-entry valid/ready circular buffer with optional ready-cut and empty bypass.
module gnrl_pipe_fifo
   import gnrl_pipe_fifo_pkg::*;
#(
   parameter int DP        = 2,
   parameter int DW        = 32,
   parameter int CUT_READY = 0,
   parameter int PASS      = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     i_vld,
   output logic                     i_rdy,
   input  logic [DW-1:0]            i_dat,
   output logic                     o_vld,
   input  logic                     o_rdy,
   output logic [DW-1:0]            o_dat,
   output logic [clog2(DP+1)-1:0]   count
);

   localparam int CW = clog2(DP+1);
   localparam int PW = clog2(DP);

   generate
      if (DP < DP_MIN || DP > DP_MAX) begin : g_dp_chk
         $error("gnrl_pipe_fifo: DP=%0d outside legal range 1..64", DP);
      end
   endgenerate

   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DP-1:0][DW-1:0] mem_q;
   logic [DP-1:0]         mem_en;
   logic                  empty, full, push, pop, byp, push_st, pop_st;
   logic                  wr_en, rd_en, cnt_en;

   // Pointers wrap at DP-1, so DP need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DP-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DP));

   assign o_vld = ~flush & (~empty | ((PASS != 0) & i_vld));
   assign pop   = o_vld & o_rdy;
   assign i_rdy = ~flush & (~full | ((CUT_READY == 0) & pop));
   assign push  = i_vld & i_rdy;

   // A bypassed word never touches storage, so neither side moves.
   assign byp     = (PASS != 0) & empty & pop;
   assign push_st = push & ~byp;
   assign pop_st  = pop & ~empty;

   always_comb begin
      wr_en  = flush | push_st;
      rd_en  = flush | pop_st;
      cnt_en = flush | (push_st ^ pop_st);
      wr_d   = flush ? '0 : ptr_inc(wr_q);
      rd_d   = flush ? '0 : ptr_inc(rd_q);
      cnt_d  = flush ? '0 : (push_st ? cnt_q + CW'(1) : cnt_q - CW'(1));
      for (int i = 0; i < DP; i++) mem_en[i] = push_st & (wr_q == PW'(i));
   end

   gnrl_dfflra #(.W(PW)) u_wr  (.clk(clk), .rst(rst), .en_i(wr_en),  .d_i(wr_d),  .q_o(wr_q));
   gnrl_dfflra #(.W(PW)) u_rd  (.clk(clk), .rst(rst), .en_i(rd_en),  .d_i(rd_d),  .q_o(rd_q));
   gnrl_dfflra #(.W(CW)) u_cnt (.clk(clk), .rst(rst), .en_i(cnt_en), .d_i(cnt_d), .q_o(cnt_q));

   for (genvar i = 0; i < DP; i++) begin : g_mem
      gnrl_dfflra #(.W(DW)) u_ent (
         .clk(clk), .rst(rst), .en_i(mem_en[i]), .d_i(i_dat), .q_o(mem_q[i])
      );
   end

   always_comb begin
      o_dat = '0;
      for (int i = 0; i < DP; i++) begin
         if (rd_q == PW'(i)) o_dat = mem_q[i];
      end
      if ((PASS != 0) && empty) o_dat = i_dat;
   end

   assign count = cnt_q;

endmodule

// File: tb/tb_gnrl_pipe_fifo.sv
// Bench: four buffer configurations checked against a queue-level reference model.
module tb_gnrl_pipe_fifo;

   function automatic int p_dp(input int g);
      case (g)
         0: return 4;
         1: return 4;
         2: return 2;
         default: return 3;
      endcase
   endfunction
   function automatic int p_cr(input int g);
      return (g == 1) ? 1 : 0;
   endfunction
   function automatic int p_pa(input int g);
      return (g == 2) ? 1 : 0;
   endfunction

   logic clk = 1'b0;
   logic rst;
   logic [3:0]      iv, ordy, fl, irdy, ov;
   logic [3:0][7:0] idat, odat, cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: per-lane ordered storage and occupancy.
   logic [7:0] mbuf [4][8];
   int         msz  [4];
   bit         acc  [4];
   logic [7:0] got3 [16];
   int         n3;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DPV = p_dp(g);
      localparam int CWV = gnrl_pipe_fifo_pkg::clog2(DPV + 1);
      logic [CWV-1:0] c;
      gnrl_pipe_fifo #(.DP(DPV), .DW(8), .CUT_READY(p_cr(g)), .PASS(p_pa(g))) u_dut (
         .clk(clk), .rst(rst), .flush(fl[g]),
         .i_vld(iv[g]), .i_rdy(irdy[g]), .i_dat(idat[g]),
         .o_vld(ov[g]), .o_rdy(ordy[g]), .o_dat(odat[g]),
         .count(c)
      );
      assign cnt[g] = 8'(c);
   end

   task automatic chk(input string tag, input int g, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s u%0d got=%0h exp=%0h", tag, g, got, exp);
      end
   endtask

   // Check every lane against the model mid-cycle, then advance the model at the edge.
   task automatic tick();
      logic       ev, er;
      logic [7:0] ed;
      bit         pu [4];
      bit         po [4];
      bit         we;
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         ev = !fl[g] && (msz[g] > 0 || (p_pa(g) != 0 && iv[g]));
         er = !fl[g] && (msz[g] < p_dp(g) || (p_cr(g) == 0 && ev && ordy[g]));
         ed = (msz[g] > 0) ? mbuf[g][0] : idat[g];
         chk("o_vld", g, 32'(ov[g]), 32'(ev));
         chk("i_rdy", g, 32'(irdy[g]), 32'(er));
         chk("count", g, 32'(cnt[g]), msz[g]);
         if (ev) chk("o_dat", g, 32'(odat[g]), 32'(ed));
         pu[g] = iv[g] && er;
         po[g] = ev && ordy[g];
      end
      @(posedge clk);
      for (int g = 0; g < 4; g++) begin
         acc[g] = pu[g];
         if (fl[g]) msz[g] = 0;
         else begin
            we = (msz[g] == 0);
            if (po[g] && !we) begin
               if (g == 3 && n3 < 16) begin got3[n3] = mbuf[g][0]; n3++; end
               for (int k = 0; k < 7; k++) mbuf[g][k] = mbuf[g][k+1];
               msz[g]--;
            end
            if (pu[g] && !(po[g] && we)) begin
               mbuf[g][msz[g]] = idat[g];
               msz[g]++;
            end
         end
      end
      #1;
   endtask

   initial begin
      logic [7:0] dexp [4];
      int nxt;
      dexp = '{8'h22, 8'h33, 8'h44, 8'h55};
      for (int g = 0; g < 4; g++) begin msz[g] = 0; acc[g] = 0; end
      n3 = 0;
      iv = '0; ordy = '0; fl = '0; idat = '0;
      rst = 1'b1;
      #12;
      for (int g = 0; g < 4; g++) begin
         chk("rst_ovld", g, 32'(ov[g]), 0);
         chk("rst_irdy", g, 32'(irdy[g]), 1);
         chk("rst_cnt",  g, 32'(cnt[g]), 0);
         if (p_pa(g) == 0) chk("rst_odat", g, 32'(odat[g]), 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Fill lanes 0 (CUT_READY=0) and 1 (CUT_READY=1) with o_rdy low.
      for (int k = 0; k < 4; k++) begin
         iv[0] = 1'b1; iv[1] = 1'b1;
         idat[0] = 8'(17 * (k + 1)); idat[1] = 8'(17 * (k + 1));
         tick();
      end
      iv[0] = 1'b0; iv[1] = 1'b0; #1;
      chk("fill_cnt", 0, 32'(cnt[0]), 4);
      chk("fill_rdy", 0, 32'(irdy[0]), 0);
      chk("fill_cnt", 1, 32'(cnt[1]), 4);
      chk("fill_rdy", 1, 32'(irdy[1]), 0);

      // Full with simultaneous push and pop.
      iv[0] = 1'b1; iv[1] = 1'b1; idat[0] = 8'h55; idat[1] = 8'h55;
      ordy[0] = 1'b1; ordy[1] = 1'b1; #1;
      chk("full_rdy", 0, 32'(irdy[0]), 1);
      chk("full_rdy", 1, 32'(irdy[1]), 0);
      chk("full_head", 0, 32'(odat[0]), 32'h11);
      tick();
      iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b0; ordy[1] = 1'b0; #1;
      chk("full_cnt", 0, 32'(cnt[0]), 4);
      chk("full_cnt", 1, 32'(cnt[1]), 3);

      // Drain in order.
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 chk("drain_dat", 0, 32'(odat[0]), 32'(dexp[k]));
         tick();
      end
      ordy[0] = 1'b0; ordy[1] = 1'b0; #1;
      chk("drain_cnt", 0, 32'(cnt[0]), 0);
      chk("drain_cnt", 1, 32'(cnt[1]), 0);

      // Bypass on the PASS lane.
      iv[2] = 1'b1; idat[2] = 8'hAB; ordy[2] = 1'b1; #1;
      chk("byp_vld", 2, 32'(ov[2]), 1);
      chk("byp_dat", 2, 32'(odat[2]), 32'hAB);
      tick();
      chk("byp_cnt", 2, 32'(cnt[2]), 0);
      ordy[2] = 1'b0;
      tick();
      iv[2] = 1'b0; #1;
      chk("byp_store", 2, 32'(cnt[2]), 1);
      ordy[2] = 1'b1;
      tick();
      ordy[2] = 1'b0;

      // Flush with count=3 and both handshakes requested.
      for (int k = 0; k < 3; k++) begin
         iv[0] = 1'b1; idat[0] = 8'(8'h61 + k);
         tick();
      end
      chk("fl_pre", 0, 32'(cnt[0]), 3);
      fl[0] = 1'b1; iv[0] = 1'b1; idat[0] = 8'h64; ordy[0] = 1'b1; #1;
      chk("fl_rdy", 0, 32'(irdy[0]), 0);
      chk("fl_vld", 0, 32'(ov[0]), 0);
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0; #1;
      chk("fl_cnt", 0, 32'(cnt[0]), 0);
      chk("fl_vld2", 0, 32'(ov[0]), 0);

      // Wrap on DP=3 with random stalls.
      nxt = 0; n3 = 0;
      for (int cyc = 0; cyc < 300 && n3 < 10; cyc++) begin
         if (!iv[3] && nxt < 10 && $urandom_range(0, 3) != 0) begin
            iv[3] = 1'b1; idat[3] = 8'(nxt);
         end
         ordy[3] = ($urandom_range(0, 2) != 0);
         tick();
         if (acc[3]) begin iv[3] = 1'b0; nxt++; end
      end
      chk("wrap_n", 3, n3, 10);
      for (int k = 0; k < 10; k++) chk("wrap_ord", 3, 32'(got3[k]), k);
      iv[3] = 1'b0; ordy[3] = 1'b0;

      // Random traffic on all lanes, including occasional flush.
      for (int cyc = 0; cyc < 120; cyc++) begin
         for (int g = 0; g < 4; g++) begin
            if (!iv[g]) begin
               iv[g] = 1'($urandom_range(0, 1));
               idat[g] = 8'($urandom);
            end
            ordy[g] = 1'($urandom_range(0, 1));
            fl[g] = ($urandom_range(0, 19) == 0);
         end
         tick();
         for (int g = 0; g < 4; g++) if (acc[g]) iv[g] = 1'b0;
      end
      iv = '0; fl = '0; ordy = '1;
      for (int k = 0; k < 5; k++) tick();
      ordy = '0;

      // Asynchronous reset between edges with two entries held.
      for (int k = 0; k < 2; k++) begin
         iv[0] = 1'b1; idat[0] = 8'(8'hA0 + k);
         tick();
      end
      iv[0] = 1'b0;
      chk("ar_pre", 0, 32'(cnt[0]), 2);
      #2 rst = 1'b1;
      #1;
      chk("ar_vld", 0, 32'(ov[0]), 0);
      chk("ar_cnt", 0, 32'(cnt[0]), 0);
      for (int g = 0; g < 4; g++) msz[g] = 0;
      #3 rst = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b1; idat[0] = 8'h77;
      tick();
      iv[0] = 1'b0; #1;
      chk("ar_vld2", 0, 32'(ov[0]), 1);
      chk("ar_dat", 0, 32'(odat[0]), 32'h77);
      chk("ar_cnt2", 0, 32'(cnt[0]), 1);
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0; #1;
      chk("ar_cnt3", 0, 32'(cnt[0]), 0);
      chk("ar_vld3", 0, 32'(ov[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
